instr_fetch_unit: RTL

Instruction fetch stage placed directly upstream of the single-cycle `riscv` core datapath. Owns the fetch program counter and issues sequential word requests to instruction memory over a valid/ready request channel. Collects in-order responses into a small prefetch FIFO and hands instructions with their PCs to the decode/datapath side over a valid/ready channel. Handles control-flow redirects (taken branch, JAL, JALR) by flushing the FIFO and discarding in-flight responses.

---
 rtl/instr_fetch_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetch PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Build option IFU_BYPASS_EN: a response reaches instr_* combinationally when the FIFO is empty.

// Generic FIFO with synchronous flush; head is read combinationally from storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none inside; the caller guarantees no push when full and no pop when empty.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   core_clk,
    input  logic                   arst_n,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (wr_vld && !flush) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_rdy) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_vld) - CW'(rd_rdy);
        end
    end
endmodule

// Fetch stage ahead of the riscv datapath; owns fetch_pc and the prefetch queue.
// Latency: response to instr_valid 1 cycle (0 with IFU_BYPASS_EN and empty FIFO); redirect to new request 1 cycle.
// Backpressure: a request needs a free FIFO slot not already reserved by an outstanding request.
module instr_fetch_unit #(
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [DATA_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [DATA_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [DATA_W-1:0] instr_pc
);
    localparam int                CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

    logic                run;
    logic [DATA_W-1:0]   fetch_pc;
    logic [DATA_W-1:0]   last_pc;
    logic [DATA_W-1:0]   rsp_pc;
    logic [DATA_W-1:0]   head_pc;
    logic [DATA_W-1:0]   head_data;
    logic [2*DATA_W-1:0] head_ent;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard_cnt;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       pcq_count;
    logic [CW:0]         credit_used;
    logic                req_fire;
    logic                rsp_vld;
    logic                rsp_keep;
    logic                fifo_vld;
    logic                fifo_push;
    logic                fifo_pop;
    logic                byp;
    logic                consume;

    // Outstanding requests already own a FIFO slot, so the FIFO can never overflow.
    assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = run && (credit_used < (CW+1)'(FIFO_DEPTH)) && !redirect_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A beat with nothing in the PC side-queue belongs to a pre-reset request and is ignored.
    assign rsp_vld   = imem_rsp_valid && (pcq_count != '0);
    assign rsp_keep  = rsp_vld && (discard_cnt == '0) && !redirect_valid;
    assign fifo_vld  = (fifo_count != '0);
    assign head_pc   = head_ent[2*DATA_W-1:DATA_W];
    assign head_data = head_ent[DATA_W-1:0];

`ifdef IFU_BYPASS_EN
    assign byp = rsp_keep && !fifo_vld;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid = fifo_vld || byp;
    assign consume     = instr_valid && instr_ready;
    assign fifo_push   = rsp_keep && !(byp && instr_ready);
    assign fifo_pop    = fifo_vld && instr_ready;

    always_comb begin
        instr_data = NOP;
        instr_pc   = last_pc;
        if (fifo_vld) begin
            instr_data = head_data;
            instr_pc   = head_pc;
        end else if (byp) begin
            instr_data = imem_rsp_data;
            instr_pc   = rsp_pc;
        end
    end

    ifu_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_q (
        .core_clk (clk),
        .arst_n   (reset),
        .flush    (1'b0),
        .wr_vld   (req_fire),
        .wr_dat   (fetch_pc),
        .rd_rdy   (rsp_vld),
        .rd_dat   (rsp_pc),
        .count    (pcq_count)
    );

    ifu_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_pf_q (
        .core_clk (clk),
        .arst_n   (reset),
        .flush    (redirect_valid),
        .wr_vld   (fifo_push),
        .wr_dat   ({rsp_pc, imem_rsp_data}),
        .rd_rdy   (fifo_pop),
        .rd_dat   (head_ent),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            last_pc     <= RESET_PC;
            outstanding <= '0;
            discard_cnt <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_vld);
            if (redirect_valid) begin
                fetch_pc    <= redirect_pc & ~DATA_W'(3);
                discard_cnt <= outstanding - CW'(rsp_vld);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + DATA_W'(4);
                end
                if (rsp_vld && (discard_cnt != '0)) begin
                    discard_cnt <= discard_cnt - CW'(1);
                end
            end
            if (consume) begin
                last_pc <= instr_pc;
            end
        end
    end
endmodule
